// File: rtl/store_buffer_pkg.sv
// Shared store-path definitions: LS_SEL codes, RAM size encodings and the FIFO entry layout.
// Mirrors the id_def.v encodings so the store buffer can be compiled standalone.
package store_buffer_pkg;

    localparam logic [3:0] LS_SEL_LB  = 4'd0;
    localparam logic [3:0] LS_SEL_LBU = 4'd1;
    localparam logic [3:0] LS_SEL_LH  = 4'd2;
    localparam logic [3:0] LS_SEL_LHU = 4'd3;
    localparam logic [3:0] LS_SEL_LW  = 4'd4;
    localparam logic [3:0] LS_SEL_LWL = 4'd5;
    localparam logic [3:0] LS_SEL_LWR = 4'd6;
    localparam logic [3:0] LS_SEL_SB  = 4'd8;
    localparam logic [3:0] LS_SEL_SH  = 4'd9;
    localparam logic [3:0] LS_SEL_SW  = 4'd10;
    localparam logic [3:0] LS_SEL_SWL = 4'd11;
    localparam logic [3:0] LS_SEL_SWR = 4'd12;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } sb_entry_t;

    function automatic logic is_store_sel(input logic [3:0] sel);
        case (sel)
            LS_SEL_SB, LS_SEL_SH, LS_SEL_SW, LS_SEL_SWL, LS_SEL_SWR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer_store_align.sv
// Store formatter: turns a store code, byte address and rt value into
// RAM size, byte strobes, lane-aligned write data and issue address.
module store_align
    import store_buffer_pkg::*;
(
    input  logic [3:0]  st_sel,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] addr
);

    logic [1:0] a_s;
    assign a_s = st_addr[1:0];

    // Formatting table for SB/SH/SW/SWL/SWR; unaligned word stores issue on the word address.
    always_comb begin
        size  = SIZE_BYTE;
        wstrb = 4'b0000;
        wdata = 32'h0000_0000;
        addr  = st_addr;
        case (st_sel)
            LS_SEL_SB: begin
                size  = SIZE_BYTE;
                wstrb = 4'b0001 << a_s;
                wdata = {4{st_data[7:0]}};
            end
            LS_SEL_SH: begin
                size  = SIZE_HALF;
                wstrb = a_s[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            LS_SEL_SW: begin
                size  = SIZE_WORD;
                wstrb = 4'b1111;
                wdata = st_data;
            end
            LS_SEL_SWL: begin
                size = SIZE_WORD;
                addr = {st_addr[31:2], 2'b00};
                case (a_s)
                    2'd0:    begin wstrb = 4'b0001; wdata = {24'h000000, st_data[31:24]}; end
                    2'd1:    begin wstrb = 4'b0011; wdata = {16'h0000, st_data[31:16]}; end
                    2'd2:    begin wstrb = 4'b0111; wdata = {8'h00, st_data[31:8]}; end
                    default: begin wstrb = 4'b1111; wdata = st_data; end
                endcase
            end
            LS_SEL_SWR: begin
                size = SIZE_WORD;
                addr = {st_addr[31:2], 2'b00};
                case (a_s)
                    2'd0:    begin wstrb = 4'b1111; wdata = st_data; end
                    2'd1:    begin wstrb = 4'b1110; wdata = {st_data[23:0], 8'h00}; end
                    2'd2:    begin wstrb = 4'b1100; wdata = {st_data[15:0], 16'h0000}; end
                    default: begin wstrb = 4'b1000; wdata = {st_data[7:0], 24'h000000}; end
                endcase
            end
            default: begin
                size  = SIZE_BYTE;
                wstrb = 4'b0000;
                wdata = 32'h0000_0000;
                addr  = st_addr;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO with a single-outstanding RAM drain FSM and
// load-after-store word hazard detection.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        st_valid,
    input  logic [3:0]  st_sel,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    input  logic        ld_check,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        sb_empty,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok
);

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_REQ  = 2'd1,
        DRAIN_WAIT = 2'd2
    } drain_state_t;

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    sb_entry_t          entries_r [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [PTR_W:0]     count_r;
    drain_state_t       state_r;
    drain_state_t       state_s;

    logic [1:0]         fmt_size_s;
    logic [3:0]         fmt_wstrb_s;
    logic [31:0]        fmt_wdata_s;
    logic [31:0]        fmt_addr_s;
    sb_entry_t          fmt_s;
    logic               push_s;
    logic               pop_s;
    logic               hit_s;
    logic               unused_ld_low_s;

    store_align u_align (
        .st_sel  (st_sel),
        .st_addr (st_addr),
        .st_data (st_data),
        .size    (fmt_size_s),
        .wstrb   (fmt_wstrb_s),
        .wdata   (fmt_wdata_s),
        .addr    (fmt_addr_s)
    );

    assign fmt_s           = '{addr: fmt_addr_s, size: fmt_size_s, wstrb: fmt_wstrb_s, wdata: fmt_wdata_s};
    assign st_ready        = (count_r != FULL_COUNT);
    assign push_s          = st_valid && st_ready && is_store_sel(st_sel);
    assign pop_s           = (state_r == DRAIN_WAIT) && data_data_ok;
    assign unused_ld_low_s = ^ld_addr[1:0];

    // FIFO storage, pointers and occupancy; a same-cycle pop only frees the slot next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                entries_r[tail_r] <= fmt_s;
                tail_r            <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Drain state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= DRAIN_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Drain next-state; a push into an empty buffer requests on the very next cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            DRAIN_IDLE: begin
                if ((count_r != '0) || push_s) state_s = DRAIN_REQ;
                else                           state_s = DRAIN_IDLE;
            end
            DRAIN_REQ: begin
                if (data_addr_ok) state_s = DRAIN_WAIT;
                else              state_s = DRAIN_REQ;
            end
            DRAIN_WAIT: begin
                if (data_data_ok) begin
                    if (count_r > (PTR_W + 1)'(1)) state_s = DRAIN_REQ;
                    else                           state_s = DRAIN_IDLE;
                end else begin
                    state_s = DRAIN_WAIT;
                end
            end
            default: state_s = DRAIN_IDLE;
        endcase
    end

    // Word-address match against every occupied slot, in-flight head included.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PTR_W'(PTR_W'(i) - head_r)} < count_r) &&
                (entries_r[i].addr[31:2] == ld_addr[31:2])) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign ld_hit     = ld_check && hit_s;
    assign sb_empty   = (count_r == '0) && (state_r == DRAIN_IDLE);
    assign data_req   = (state_r == DRAIN_REQ);
    assign data_wr    = data_req;
    assign data_size  = entries_r[head_r].size;
    assign data_addr  = entries_r[head_r].addr;
    assign data_wstrb = entries_r[head_r].wstrb;
    assign data_wdata = entries_r[head_r].wdata;

endmodule
